// File: rtl/fft_bfly_seq.sv
// -----------------------------------------------------------------------------
// fft_bfly_seq
//   Sequential radix-2 DIT butterfly engine working in place on a
//   single-port synchronous sample RAM. One butterfly takes 6 cycles:
//   IDLE (accept) -> RD_A -> RD_B -> MUL -> WR_A -> WR_B -> IDLE.
//
//   Top  = A + W*B,  Bottom = A - W*B, components Q1.(DATA_W-1).
//
//   Configuration macro:
//     BFLY_SCALE_EN  defined   : each output component = sum >>> 1 (floor),
//                                per-stage 1/2 scaling, never saturates.
//                    undefined : each output component saturated to the
//                                signed DATA_W range.
//
//   Handshake: a pair is taken on a rising edge where pair_valid=1 and
//   pair_ready=1 (and reset=0). pair_ready is 1 only in IDLE; pair_valid in
//   any other state is ignored and nothing is queued.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pair_valid/ready    pair handshake
//   pair_ja, pair_jb    top / bottom sample addresses
//   pair_wr, pair_wi    twiddle real / imag (signed)
//   pair_last           final pair of the transform
//   mem_addr, mem_we    sample RAM address / write strobe
//   mem_wdata           write data {re, im}
//   mem_rdata           read data {re, im}, one cycle after its address
//   done                one-cycle pulse after the last butterfly's WR_B
//   state_dbg           current FSM state (debug observation)
// -----------------------------------------------------------------------------
module fft_bfly_seq #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pair_valid,
   output logic                  pair_ready,
   input  logic [ADDR_W-1:0]     pair_ja,
   input  logic [ADDR_W-1:0]     pair_jb,
   input  logic [DATA_W-1:0]     pair_wr,
   input  logic [DATA_W-1:0]     pair_wi,
   input  logic                  pair_last,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [2*DATA_W-1:0]   mem_wdata,
   input  logic [2*DATA_W-1:0]   mem_rdata,
   output logic                  done,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      MUL  = 3'd3,
      WR_A = 3'd4,
      WR_B = 3'd5
   } state_t;

   localparam int PW = 2 * DATA_W + 1;   // full-precision product/difference width
   localparam int SW = DATA_W + 2;       // butterfly sum width

   state_t                state;
   logic [ADDR_W-1:0]     ja_q, jb_q;
   logic [DATA_W-1:0]     wr_q, wi_q;
   logic                  last_q;
   logic [2*DATA_W-1:0]   a_q;
   logic [DATA_W:0]       p_r_q, p_i_q;

   // Combinational datapath
   logic [DATA_W-1:0]     b_r, b_i;
   logic [PW-1:0]         prod_r, prod_i;
   logic [DATA_W:0]       p_r_next, p_i_next;
   logic [SW-1:0]         add_r, add_i, sub_r, sub_i;

   assign state_dbg = state;

   // Sign-extend a DATA_W value to the product width. Multiplying two
   // extended operands modulo 2^PW yields the exact signed product.
   function automatic logic [PW-1:0] sx_p(input logic [DATA_W-1:0] x);
      return {{(DATA_W+1){x[DATA_W-1]}}, x};
   endfunction

   // Output conditioning of one DATA_W+2 bit sum.
   function automatic logic [DATA_W-1:0] cond(input logic [SW-1:0] s);
`ifdef BFLY_SCALE_EN
      // Floor divide by two; the result is simply wrapped into DATA_W bits.
      return s[DATA_W:1];
`else
      // In range only when the three top bits agree.
      if (!s[SW-1] && (s[DATA_W:DATA_W-1] != 2'b00))
         return {1'b0, {(DATA_W-1){1'b1}}};
      else if (s[SW-1] && (s[DATA_W:DATA_W-1] != 2'b11))
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return s[DATA_W-1:0];
`endif
   endfunction

   always_comb begin
      b_r    = mem_rdata[2*DATA_W-1:DATA_W];
      b_i    = mem_rdata[DATA_W-1:0];
      prod_r = sx_p(wr_q) * sx_p(b_r) - sx_p(wi_q) * sx_p(b_i);
      prod_i = sx_p(wr_q) * sx_p(b_i) + sx_p(wi_q) * sx_p(b_r);
      // Arithmetic shift right by DATA_W-1 then keep DATA_W+1 bits: a slice.
      p_r_next = prod_r[2*DATA_W-1:DATA_W-1];
      p_i_next = prod_i[2*DATA_W-1:DATA_W-1];
      // Top sum is prepared at the MUL->WR_A edge, so it uses the product
      // being registered on that same edge; the bottom sum uses the register.
      add_r = {{2{a_q[2*DATA_W-1]}}, a_q[2*DATA_W-1:DATA_W]} + {p_r_next[DATA_W], p_r_next};
      add_i = {{2{a_q[DATA_W-1]}},   a_q[DATA_W-1:0]}        + {p_i_next[DATA_W], p_i_next};
      sub_r = {{2{a_q[2*DATA_W-1]}}, a_q[2*DATA_W-1:DATA_W]} - {p_r_q[DATA_W], p_r_q};
      sub_i = {{2{a_q[DATA_W-1]}},   a_q[DATA_W-1:0]}        - {p_i_q[DATA_W], p_i_q};
   end

   // Single FSM block; all outputs are registered and set on the edge that
   // enters the state in which they apply. B itself is not kept: P = W*B is
   // captured directly from the read data in MUL.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pair_ready <= 1'b1;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         done       <= 1'b0;
         ja_q       <= '0;
         jb_q       <= '0;
         wr_q       <= '0;
         wi_q       <= '0;
         last_q     <= 1'b0;
         a_q        <= '0;
         p_r_q      <= '0;
         p_i_q      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pair_valid) begin
                  ja_q       <= pair_ja;
                  jb_q       <= pair_jb;
                  wr_q       <= pair_wr;
                  wi_q       <= pair_wi;
                  last_q     <= pair_last;
                  pair_ready <= 1'b0;
                  mem_addr   <= pair_ja;
                  state      <= RD_A;
               end
            end
            RD_A: begin
               mem_addr <= jb_q;
               state    <= RD_B;
            end
            RD_B: begin
               a_q   <= mem_rdata;
               state <= MUL;
            end
            MUL: begin
               p_r_q     <= p_r_next;
               p_i_q     <= p_i_next;
               mem_addr  <= ja_q;
               mem_we    <= 1'b1;
               mem_wdata <= {cond(add_r), cond(add_i)};
               state     <= WR_A;
            end
            WR_A: begin
               mem_addr  <= jb_q;
               mem_we    <= 1'b1;
               mem_wdata <= {cond(sub_r), cond(sub_i)};
               state     <= WR_B;
            end
            WR_B: begin
               mem_addr   <= '0;
               mem_we     <= 1'b0;
               mem_wdata  <= '0;
               pair_ready <= 1'b1;
               done       <= last_q;
               state      <= IDLE;
            end
            default: begin
               mem_addr   <= '0;
               mem_we     <= 1'b0;
               mem_wdata  <= '0;
               pair_ready <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_bfly_seq.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_seq
//   Bench for fft_bfly_seq with a synchronous sample RAM model. A behavioural
//   model tracks when the block is busy and computes each butterfly's two
//   writes with plain integer arithmetic; one negedge process compares the
//   DUT outputs against it every cycle. Directed cases pin hand-computed
//   results. Honours BFLY_SCALE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fft_bfly_seq;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int EW = 32 + AW + 2*DW;   // {cycle, addr, data}

`ifdef BFLY_SCALE_EN
   localparam logic [31:0] E32A = {16'd599,   16'd0};
   localparam logic [31:0] E32B = {16'd400,   16'd0};
   localparam logic [31:0] E33A = {16'd19999, 16'd0};
   localparam logic [31:0] E33B = {16'd10000, 16'd0};
   localparam logic [31:0] E34A = {16'd0,     16'd49};
   localparam logic [31:0] E34B = {16'd0,     16'hFFCE};
`else
   localparam logic [31:0] E32A = {16'd1199,  16'd0};
   localparam logic [31:0] E32B = {16'd801,   16'd0};
   localparam logic [31:0] E33A = {16'd32767, 16'd0};
   localparam logic [31:0] E33B = {16'd20001, 16'd0};
   localparam logic [31:0] E34A = {16'd0,     16'd99};
   localparam logic [31:0] E34B = {16'd0,     16'hFF9D};
`endif

   logic            clk, reset;
   logic            pair_valid, pair_ready, pair_last;
   logic [AW-1:0]   pair_ja, pair_jb;
   logic [DW-1:0]   pair_wr, pair_wi;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [2*DW-1:0] mem_wdata, mem_rdata;
   logic            done;
   logic [2:0]      state_dbg;

   fft_bfly_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .pair_valid(pair_valid), .pair_ready(pair_ready),
      .pair_ja(pair_ja), .pair_jb(pair_jb),
      .pair_wr(pair_wr), .pair_wi(pair_wi), .pair_last(pair_last),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .done(done), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RAM model + preload port ----------------
   logic [2*DW-1:0] ram [0:31];
   logic [2*DW-1:0] ref_mem [0:31];
   logic            pl_we;
   logic [AW-1:0]   pl_addr;
   logic [2*DW-1:0] pl_data;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else if (pl_we) ram[pl_addr] <= pl_data;
      mem_rdata <= ram[mem_addr];
   end

   // ---------------- scoreboard state ----------------
   int  n_checks = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  busy_last = -1;
   int  done_cyc = -1;
   int  wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
   int  last_acc_edge = 0, acc_gap = 0;
   bit  started = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] commit_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic longint wrap_s(longint x, int n);
      longint m = longint'(1) << n;
      longint y = x % m;
      if (y < 0) y += m;
      if (y >= (m >> 1)) y -= m;
      return y;
   endfunction

   function automatic logic [DW-1:0] out_cond(longint s);
      longint mx = (longint'(1) << (DW-1)) - 1;
      longint mn = -(longint'(1) << (DW-1));
`ifdef BFLY_SCALE_EN
      return DW'(wrap_s(s >>> 1, DW));
`else
      if (s > mx) return DW'(mx);
      if (s < mn) return DW'(mn);
      return DW'(s);
`endif
   endfunction

   task automatic bfly(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                       input logic [DW-1:0] wr, input logic [DW-1:0] wi,
                       output logic [2*DW-1:0] top, output logic [2*DW-1:0] bot);
      longint ar = longint'($signed(a[2*DW-1:DW]));
      longint ai = longint'($signed(a[DW-1:0]));
      longint br = longint'($signed(b[2*DW-1:DW]));
      longint bi = longint'($signed(b[DW-1:0]));
      longint w_r = longint'($signed(wr));
      longint w_i = longint'($signed(wi));
      longint pr = wrap_s((w_r*br - w_i*bi) >>> (DW-1), DW+1);
      longint pi = wrap_s((w_r*bi + w_i*br) >>> (DW-1), DW+1);
      top = {out_cond(ar + pr), out_cond(ai + pi)};
      bot = {out_cond(ar - pr), out_cond(ai - pi)};
   endtask

   // Model update on each rising edge: commit writes that land on this edge,
   // then apply reset or acceptance.
   always @(posedge clk) begin : model
      int e;
      logic [2*DW-1:0] top, bot;
      logic [EW-1:0] c;
      e = cyc;
      while (commit_q.size() > 0 && int'(commit_q[0][EW-1 -: 32]) == e) begin
         c = commit_q.pop_front();
         ref_mem[c[2*DW +: AW]] = c[2*DW-1:0];
      end
      if (pl_we) ref_mem[pl_addr] = pl_data;
      if (reset) begin
         started   = 1;
         exp_q.delete();
         commit_q.delete();
         busy_last = e - 1;
         done_cyc  = -1;
      end else if (started && pair_valid && (e > busy_last + 1)) begin
         bfly(ref_mem[pair_ja], ref_mem[pair_jb], pair_wr, pair_wi, top, bot);
         exp_q.push_back({32'(e+3), pair_ja, top});
         exp_q.push_back({32'(e+4), pair_jb, bot});
         commit_q.push_back({32'(e+4), pair_ja, top});
         commit_q.push_back({32'(e+5), pair_jb, bot});
         busy_last = e + 4;
         if (pair_last) done_cyc = e + 5;
         acc_gap = e - last_acc_edge;
         last_acc_edge = e;
         acc_cnt++;
      end
      cyc = cyc + 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      int k;
      bit exp_rdy;
      logic [EW-1:0] ent;
      if (started) begin
         k = cyc - 1;
         exp_rdy = (k > busy_last);
         check("pair_ready", 64'(pair_ready), 64'(exp_rdy));
         check("done", 64'(done), 64'(k == done_cyc));
         if (exp_rdy)
            check("idle_outputs", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
         if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == k) begin
            ent = exp_q.pop_front();
            check("write_we", 64'(mem_we), 64'(1));
            check("write_addr", 64'(mem_addr), 64'(ent[2*DW +: AW]));
            check("write_data", 64'(mem_wdata), 64'(ent[2*DW-1:0]));
         end else begin
            check("no_write", 64'({mem_we, mem_wdata}), 64'(0));
         end
         if (mem_we) wr_cnt++;
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [AW-1:0] a, input logic [2*DW-1:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   task automatic send_pair(input logic [AW-1:0] ja, input logic [AW-1:0] jb,
                            input logic [DW-1:0] wr, input logic [DW-1:0] wi,
                            input logic last);
      bit got = 0;
      pair_ja = ja; pair_jb = jb; pair_wr = wr; pair_wi = wi; pair_last = last;
      pair_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (pair_ready) begin got = 1; break; end
      end
      if (!got) begin
         n_checks++; n_err++;
         $display("FAIL send_timeout: got ready=0 required ready=1 within 30 cycles");
      end
      @(posedge clk); #1;
      pair_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && pair_ready && (cyc - 1 > done_cyc)) begin ok = 1; break; end
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL idle_timeout: got busy required idle within 40 cycles");
      end
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [2*DW-1:0] old_a, old_b;
      int w0, d0, a0;
      reset = 1'b1; pair_valid = 1'b0; pair_last = 1'b0;
      pair_ja = '0; pair_jb = '0; pair_wr = '0; pair_wi = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 32; i++) preload(AW'(i), 32'($urandom));

      // A=(1000,0), B=(200,0), W=(32767,0)
      preload(5'd3,  {16'd1000, 16'd0});
      preload(5'd19, {16'd200,  16'd0});
      send_pair(5'd3, 5'd19, 16'd32767, 16'd0, 1'b1);
      wait_idle();
      check("req032_top", 64'(ram[3]),  64'(E32A));
      check("req032_bot", 64'(ram[19]), 64'(E32B));

      // Saturating / scaled top output
      preload(5'd5, {16'd30000, 16'd0});
      preload(5'd6, {16'd10000, 16'd0});
      send_pair(5'd5, 5'd6, 16'd32767, 16'd0, 1'b0);
      wait_idle();
      check("req033_top", 64'(ram[5]), 64'(E33A));
      check("req033_bot", 64'(ram[6]), 64'(E33B));

      // W=(0,32767): imaginary rotation, floor on negative
      preload(5'd7, {16'd0,   16'd0});
      preload(5'd8, {16'd100, 16'd0});
      send_pair(5'd7, 5'd8, 16'd0, 16'd32767, 1'b0);
      wait_idle();
      check("req034_top", 64'(ram[7]), 64'(E34A));
      check("req034_bot", 64'(ram[8]), 64'(E34B));

      // Four back-to-back pairs with pair_valid held high
      w0 = wr_cnt; d0 = done_cnt; a0 = acc_cnt;
      pair_valid = 1'b1;
      for (int p = 0; p < 4; p++) begin
         bit got = 0;
         pair_ja = AW'(2*p + 10); pair_jb = AW'(2*p + 11);
         pair_wr = DW'($urandom); pair_wi = DW'($urandom);
         pair_last = (p == 3);
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pair_ready) begin got = 1; break; end
         end
         if (!got) begin
            n_checks++; n_err++;
            $display("FAIL held_timeout: got ready=0 required ready=1");
         end
         @(posedge clk); #1;
         if (p > 0) check("held_gap", 64'(acc_gap), 64'(6));
      end
      pair_valid = 1'b0;
      wait_idle();
      check("held_accepts", 64'(acc_cnt - a0), 64'(4));
      check("held_writes", 64'(wr_cnt - w0), 64'(8));
      check("held_dones", 64'(done_cnt - d0), 64'(1));

      // pair_valid toggled with junk while busy
      a0 = acc_cnt;
      send_pair(5'd20, 5'd21, DW'($urandom), DW'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pair_valid = 1'($urandom_range(0, 1));
         pair_ja = AW'($urandom); pair_jb = AW'($urandom);
         pair_wr = DW'($urandom); pair_last = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      pair_valid = 1'b0;
      wait_idle();
      check("toggle_accepts", 64'(acc_cnt - a0), 64'(1));

      // Reset sampled at the end of RD_B abandons the butterfly
      old_a = ram[22]; old_b = ram[23];
      w0 = wr_cnt; d0 = done_cnt;
      send_pair(5'd22, 5'd23, 16'd32767, 16'd0, 1'b1);   // now in RD_A
      @(posedge clk); #1;                                 // now in RD_B
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(pair_ready), 64'(1));
      repeat (8) @(posedge clk);
      #1;
      check("reset_no_write", 64'(wr_cnt - w0), 64'(0));
      check("reset_no_done", 64'(done_cnt - d0), 64'(0));
      check("reset_ram_a", 64'(ram[22]), 64'(old_a));
      check("reset_ram_b", 64'(ram[23]), 64'(old_b));
      send_pair(5'd22, 5'd23, DW'($urandom), DW'($urandom), 1'b1);
      wait_idle();

      // Randomised pairs, including ja==jb and idle gaps
      for (int n = 0; n < 30; n++) begin
         logic [AW-1:0] ja, jb;
         ja = AW'($urandom);
         jb = ($urandom_range(0, 9) == 0) ? ja : AW'($urandom);
         send_pair(ja, jb, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 7)) @(posedge clk);
         #1;
      end
      wait_idle();

      // Final RAM image versus the model
      for (int i = 0; i < 32; i++) check("final_ram", 64'(ram[i]), 64'(ref_mem[i]));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
